// File: rtl/fp_pkg.sv
// Shared FP writeback types: flag bit positions, canonical quiet NaN,
// the buffered result entry and a NaN classifier.
package fp_pkg;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0]              data;
        logic [4:0]               rd;
        logic [FLAG_NV:FLAG_NX]   flags;
    } fp_wb_entry_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != '0);
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// In-order FIFO of writeback entries; exposes head, occupancy, per-slot
// valid mask and per-slot destination registers.
module fp_wb_fifo
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fp_wb_entry_t                 push_entry_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output fp_wb_entry_t                 head_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [DEPTH-1:0][4:0]        rd_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fp_wb_entry_t     mem_q [DEPTH];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + PTR_W'(1);
            if (pop_i)  rd_d = rd_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_i && !flush_i) mem_q[wr_q] <= push_entry_i;
        end
    end

    // Slot i is live when its distance from the read pointer is below the count.
    always_comb begin
        valid_o = '0;
        rd_o    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_o[i] = {1'b0, PTR_W'(i) - rd_q} < cnt_q;
            rd_o[i]    = mem_q[i].rd;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fp_result_wb.sv
// FP writeback stage: buffers execute results, optionally canonicalises NaNs,
// retires in order to the FP register file, accrues fflags, exports pending.
module fp_result_wb
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter bit          CANON_NAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_data,
    input  logic [4:0]  res_rd,
    input  logic [4:0]  res_flags,
    input  logic        frf_stall,
    output logic        frf_we,
    output logic [4:0]  frf_waddr,
    output logic [31:0] frf_wdata,
    input  logic        csr_we,
    input  logic [4:0]  csr_wdata,
    output logic [4:0]  fflags,
    output logic [31:0] pending
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]      count;
    fp_wb_entry_t          head;
    fp_wb_entry_t          enq_entry;
    logic [DEPTH-1:0]      slot_valid;
    logic [DEPTH-1:0][4:0] slot_rd;
    logic                  enq;
    logic                  not_empty;
    logic [4:0]            fflags_q, fflags_d;

    assign not_empty = (count != '0);
    assign res_ready = (count != CNT_W'(DEPTH));
    assign enq       = res_valid && res_ready && !flush;
    assign frf_we    = not_empty && !frf_stall && !flush;
    assign frf_waddr = not_empty ? head.rd   : '0;
    assign frf_wdata = not_empty ? head.data : '0;

    always_comb begin
        enq_entry.data  = (CANON_NAN && is_nan(res_data)) ? QNAN_CANON : res_data;
        enq_entry.rd    = res_rd;
        enq_entry.flags = res_flags;
    end

    fp_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .push_i       (enq),
        .push_entry_i (enq_entry),
        .pop_i        (frf_we),
        .count_o      (count),
        .head_o       (head),
        .valid_o      (slot_valid),
        .rd_o         (slot_rd)
    );

    // A CSR write and a retiring entry in the same cycle both land.
    always_comb begin
        fflags_d = (csr_we ? csr_wdata : fflags_q) | (frf_we ? head.flags : 5'b0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fflags_q <= '0;
        else        fflags_q <= fflags_d;
    end

    assign fflags = fflags_q;

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) pending[slot_rd[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_result_wb.sv
// Directed bench for fp_result_wb with a queue-based reference model that is
// checked against the DUT on every falling clock edge.
module tb_fp_result_wb;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic [4:0]  res_flags;
    logic        frf_stall;
    logic        frf_we;
    logic [4:0]  frf_waddr;
    logic [31:0] frf_wdata;
    logic        csr_we;
    logic [4:0]  csr_wdata;
    logic [4:0]  fflags;
    logic [31:0] pending;

    exp_t        sb[$];
    logic [4:0]  fexp = '0;
    int          ncmp = 0;
    int          nfail = 0;

    fp_result_wb #(
        .DEPTH     (DEPTH),
        .CANON_NAN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_rd    (res_rd),
        .res_flags (res_flags),
        .frf_stall (frf_stall),
        .frf_we    (frf_we),
        .frf_waddr (frf_waddr),
        .frf_wdata (frf_wdata),
        .csr_we    (csr_we),
        .csr_wdata (csr_wdata),
        .fflags    (fflags),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_data(input logic [31:0] d);
        if (d[30:23] == 8'hFF && d[22:0] != 23'd0) return 32'h7FC0_0000;
        return d;
    endfunction

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic [4:0] fl);
        res_valid = 1'b1;
        res_data  = d;
        res_rd    = rd;
        res_flags = fl;
    endtask

    // Reference model: compare outputs, then advance the model by one clock edge.
    always @(negedge clk) begin : mon
        logic        mwe;
        logic        acc;
        logic [31:0] pend;
        logic [4:0]  fnext;
        exp_t        e;
        if (!rst_n) begin
            sb.delete();
            fexp = '0;
        end
        pend = '0;
        foreach (sb[i]) pend[sb[i].rd] = 1'b1;
        mwe = rst_n && (sb.size() != 0) && !frf_stall && !flush;
        chk("mon_we", 32'(frf_we), 32'(mwe));
        chk("mon_ready", 32'(res_ready), 32'(sb.size() != DEPTH));
        chk("mon_pending", pending, pend);
        chk("mon_fflags", 32'(fflags), 32'(fexp));
        if (sb.size() != 0) begin
            chk("mon_waddr", 32'(frf_waddr), 32'(sb[0].rd));
            chk("mon_wdata", frf_wdata, sb[0].data);
        end else begin
            chk("mon_waddr_empty", 32'(frf_waddr), 32'd0);
            chk("mon_wdata_empty", frf_wdata, 32'd0);
        end
        if (rst_n) begin
            acc   = res_valid && (sb.size() != DEPTH) && !flush;
            fnext = (csr_we ? csr_wdata : fexp) | ((mwe && sb.size() != 0) ? sb[0].flags : 5'b0);
            if (flush) begin
                sb.delete();
            end else begin
                if (mwe) void'(sb.pop_front());
                if (acc) begin
                    e.data  = model_data(res_data);
                    e.rd    = res_rd;
                    e.flags = res_flags;
                    sb.push_back(e);
                end
            end
            fexp = fnext;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_rd    = '0;
        res_flags = '0;
        frf_stall = 1'b0;
        csr_we    = 1'b0;
        csr_wdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(res_ready), 32'd1);
        chk("rst_we", 32'(frf_we), 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_fflags", 32'(fflags), 32'd0);
        go();
        rst_n = 1'b1;

        // 1: single result, one-cycle latency, pending tracking
        go();
        push(32'h3F80_0000, 5'd3, 5'd0);
        @(negedge clk);
        chk("t1_no_bypass", 32'(frf_we), 32'd0);
        go();
        res_valid = 1'b0;
        @(negedge clk);
        chk("t1_we", 32'(frf_we), 32'd1);
        chk("t1_waddr", 32'(frf_waddr), 32'd3);
        chk("t1_wdata", frf_wdata, 32'h3F80_0000);
        chk("t1_pend_set", 32'(pending[3]), 32'd1);
        go();
        @(negedge clk);
        chk("t1_pend_clr", 32'(pending[3]), 32'd0);
        chk("t1_we_idle", 32'(frf_we), 32'd0);

        // 2: NaN canonicalisation, +inf passthrough, flag accrual
        go();
        push(32'hFF80_0001, 5'd7, 5'b10000);
        go();
        push(32'h7F80_0000, 5'd8, 5'b00000);
        @(negedge clk);
        chk("t2_canon", frf_wdata, 32'h7FC0_0000);
        chk("t2_fflags_pre", 32'(fflags), 32'd0);
        go();
        res_valid = 1'b0;
        @(negedge clk);
        chk("t2_inf", frf_wdata, 32'h7F80_0000);
        chk("t2_fflags", 32'(fflags), 32'b10000);
        go();

        // 3/4: stall fills FIFO; full + dequeue does not accept
        frf_stall = 1'b1;
        push(32'h4000_0000, 5'd1, 5'd0);
        @(negedge clk);
        chk("t3_ready_a", 32'(res_ready), 32'd1);
        go();
        push(32'h4040_0000, 5'd2, 5'd0);
        @(negedge clk);
        chk("t3_ready_b", 32'(res_ready), 32'd1);
        go();
        push(32'h4080_0000, 5'd4, 5'd0);
        @(negedge clk);
        chk("t3_ready_full", 32'(res_ready), 32'd0);
        chk("t3_pending", pending, 32'h0000_0006);
        go();
        @(negedge clk);
        chk("t3_held", 32'(res_ready), 32'd0);
        go();
        frf_stall = 1'b0;
        @(negedge clk);
        chk("t4_wr_a", 32'(frf_waddr), 32'd1);
        chk("t4_no_accept_full", 32'(res_ready), 32'd0);
        go();
        @(negedge clk);
        chk("t3_wr_b", 32'(frf_waddr), 32'd2);
        chk("t4_accept_next", 32'(res_ready), 32'd1);
        go();
        res_valid = 1'b0;
        @(negedge clk);
        chk("t3_wr_c", 32'(frf_waddr), 32'd4);
        chk("t3_wr_c_we", 32'(frf_we), 32'd1);
        go();

        // 4: streaming sustains one write per cycle
        for (int k = 0; k < 6; k++) begin
            push(32'h4100_0000 + 32'(k), 5'(10 + k), 5'd0);
            @(negedge clk);
            if (k > 0) begin
                chk("t4_stream_we", 32'(frf_we), 32'd1);
                chk("t4_stream_addr", 32'(frf_waddr), 32'(10 + k - 1));
            end
            go();
        end
        res_valid = 1'b0;
        @(negedge clk);
        chk("t4_stream_last", 32'(frf_waddr), 32'd15);
        go();

        // 5: CSR write and retirement in the same cycle
        push(32'h3F00_0000, 5'd20, 5'b00100);
        csr_we    = 1'b1;
        csr_wdata = 5'b00001;
        go();
        res_valid = 1'b0;
        csr_wdata = 5'b00000;
        @(negedge clk);
        chk("t5_fflags_csr", 32'(fflags), 32'b00001);
        chk("t5_retire", 32'(frf_we), 32'd1);
        go();
        csr_we = 1'b0;
        @(negedge clk);
        chk("t5_fflags_merge", 32'(fflags), 32'b00100);

        // 6: flush drops buffered and concurrent entries
        go();
        frf_stall = 1'b1;
        push(32'h3F80_0000, 5'd5, 5'd0);
        go();
        push(32'h3F80_0000, 5'd9, 5'd0);
        go();
        flush = 1'b1;
        push(32'h3F80_0000, 5'd11, 5'b00010);
        @(negedge clk);
        chk("t6_flush_we", 32'(frf_we), 32'd0);
        chk("t6_pend_pre", pending, 32'h0000_0220);
        go();
        flush     = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        chk("t6_pend_post", pending, 32'd0);
        chk("t6_ready_post", 32'(res_ready), 32'd1);
        chk("t6_fflags_kept", 32'(fflags), 32'b00100);

        // 6: asynchronous reset while stalled with entries buffered
        go();
        push(32'h3F80_0000, 5'd6, 5'b00001);
        go();
        push(32'h3F80_0000, 5'd7, 5'b00001);
        go();
        res_valid = 1'b0;
        @(negedge clk);
        chk("t6_pend_stall", pending, 32'h0000_00C0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_ready", 32'(res_ready), 32'd1);
        chk("t6_arst_we", 32'(frf_we), 32'd0);
        chk("t6_arst_pending", pending, 32'd0);
        chk("t6_arst_fflags", 32'(fflags), 32'd0);
        chk("t6_arst_waddr", 32'(frf_waddr), 32'd0);
        chk("t6_arst_wdata", frf_wdata, 32'd0);
        go();
        go();
        rst_n     = 1'b1;
        frf_stall = 1'b0;
        push(32'h3F80_0000, 5'd12, 5'b00001);
        go();
        res_valid = 1'b0;
        @(negedge clk);
        chk("t6_resume_waddr", 32'(frf_waddr), 32'd12);
        go();
        @(negedge clk);
        chk("t6_resume_fflags", 32'(fflags), 32'b00001);
        go();
        go();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
